// File: rtl/decoder_3to8_pulse_pkg.sv
// Shared types and constants for the 3-to-8 pulse decoder slice.
package dec_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned OUT_W  = 8;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_e;

  function automatic logic [OUT_W-1:0] code2onehot(input logic [CODE_W-1:0] code);
    logic [OUT_W-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_3to8_pulse_if.sv
// Code handshake and decoded-output bundle between a code source and the pulse decoder.
interface decoder_3to8_pulse_if #(
  parameter int unsigned DEPTH = 4
);
  import dec_pkg::*;

  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic              en;
  logic [CODE_W-1:0] code_in;
  logic              code_valid;
  logic              code_ready;
  logic [OUT_W-1:0]  out;
  logic              busy;
  logic              done;
  logic [LVL_W-1:0]  level;

  modport master (
    output en, code_in, code_valid,
    input  code_ready, out, busy, done, level
  );

  modport slave (
    input  en, code_in, code_valid,
    output code_ready, out, busy, done, level
  );

endinterface

// File: rtl/decoder_3to8_pulse_fifo.sv
// Small synchronous code FIFO; push/pop are self-gated against full/empty.
module sync_code_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == LVL_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + LVL_W'(1);
        2'b01:   count_q <= count_q - LVL_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/decoder_3to8_pulse.sv
// Buffers 3-bit codes and replays each as a one-hot pulse of fixed width with a zero gap.
module decoder_3to8_pulse
  import dec_pkg::*;
#(
  parameter int          HOLD_CYCLES = 4,
  parameter int          GAP_CYCLES  = 1,
  parameter int unsigned DEPTH       = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  decoder_3to8_pulse_if.slave bus
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be at least 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("GAP_CYCLES must be at least 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              done_q, done_d;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [CODE_W-1:0] fifo_code;

  sync_code_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.code_valid),
    .wdata (bus.code_in),
    .pop   (fifo_pop),
    .rdata (fifo_code),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (bus.level)
  );

  assign bus.code_ready = ~fifo_full;
  assign bus.out        = out_q;
  assign bus.done       = done_q;
  assign bus.busy       = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.en && !fifo_empty) begin
          fifo_pop = 1'b1;
          out_d    = code2onehot(fifo_code);
          cnt_d    = CNT_W'(HOLD_CYCLES - 1);
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (!bus.en) begin
          out_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          out_d   = '0;
          done_d  = 1'b1;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
          state_d = GAP;
        end
      end
      GAP: begin
        if (!bus.en) begin
          out_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!fifo_empty) begin
          // Chain straight into the next pulse so queued codes keep exact spacing.
          fifo_pop = 1'b1;
          out_d    = code2onehot(fifo_code);
          cnt_d    = CNT_W'(HOLD_CYCLES - 1);
          state_d  = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        out_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_decoder_3to8_pulse.sv
// Directed self-checking bench for decoder_3to8_pulse (default and HOLD=1/GAP=1 instances).
module tb_decoder_3to8_pulse;

  logic clk;
  logic rst_n;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] cap_val [16];
  int         cap_len [16];
  int         cap_gap [16];
  int         cap_n, cap_ng, cap_done, cap_multi;

  decoder_3to8_pulse_if #(.DEPTH(4)) b0 ();
  decoder_3to8_pulse_if #(.DEPTH(4)) b1 ();

  decoder_3to8_pulse #(
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (1),
    .DEPTH       (4)
  ) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0.slave)
  );

  decoder_3to8_pulse #(
    .HOLD_CYCLES (1),
    .GAP_CYCLES  (1),
    .DEPTH       (4)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Call at a negedge; returns at the negedge just after the accepting posedge.
  task automatic push_code(input bit sel, input logic [2:0] c);
    int n;
    n = 0;
    if (sel) begin b1.code_in = c; b1.code_valid = 1'b1; end
    else     begin b0.code_in = c; b0.code_valid = 1'b1; end
    while (!(sel ? b1.code_ready : b0.code_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL push_timeout: code_ready=0 after 100 cycles, want 1");
    end
    @(negedge clk);
    if (sel) b1.code_valid = 1'b0; else b0.code_valid = 1'b0;
  endtask

  // Records one-hot runs and the zero gaps between them, sampled at negedges.
  task automatic capture(input bit sel, input int cycles);
    logic [7:0] v, prev;
    int run;
    prev = '0; run = 0;
    cap_n = 0; cap_ng = 0; cap_done = 0; cap_multi = 0;
    for (int i = 0; i < 16; i++) begin cap_val[i] = '0; cap_len[i] = 0; cap_gap[i] = 0; end
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      v = sel ? b1.out : b0.out;
      if (sel ? b1.done : b0.done) cap_done++;
      if ($countones(v) > 1) cap_multi++;
      if (v == prev) run++;
      else begin
        if (prev != '0) begin
          if (cap_n < 16) begin cap_val[cap_n] = prev; cap_len[cap_n] = run; end
          cap_n++;
        end else if (cap_n > 0) begin
          if (cap_ng < 16) cap_gap[cap_ng] = run;
          cap_ng++;
        end
        prev = v;
        run  = 1;
      end
    end
  endtask

  task automatic wait_idle(input bit sel);
    int n;
    n = 0;
    while (((sel ? b1.busy : b0.busy) || (sel ? b1.level : b0.level) != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout: decoder still busy after 200 cycles, want idle");
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (b0.out !== 8'h00) begin n_err++; $display("FAIL reset_out: got %h want 00", b0.out); end
    n_cmp++; if (b0.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", b0.busy); end
    n_cmp++; if (b0.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", b0.done); end
    n_cmp++; if (b0.level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", b0.level); end
    n_cmp++; if (b0.code_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", b0.code_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sequence;
    b0.en = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) push_code(1'b0, 3'(i));
      end
      capture(1'b0, 50);
    join
    n_cmp++; if (cap_n !== 8) begin n_err++; $display("FAIL seq_count: got %0d pulses want 8", cap_n); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (cap_val[i] !== (8'h01 << i)) begin
        n_err++; $display("FAIL seq_val[%0d]: got %h want %h", i, cap_val[i], 8'h01 << i);
      end
      n_cmp++;
      if (cap_len[i] !== 4) begin n_err++; $display("FAIL seq_len[%0d]: got %0d want 4", i, cap_len[i]); end
    end
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (cap_gap[i] !== 1) begin n_err++; $display("FAIL seq_gap[%0d]: got %0d want 1", i, cap_gap[i]); end
    end
    n_cmp++; if (cap_done !== 8) begin n_err++; $display("FAIL seq_done: got %0d want 8", cap_done); end
    n_cmp++; if (cap_multi !== 0) begin n_err++; $display("FAIL seq_multihot: got %0d want 0", cap_multi); end
    wait_idle(1'b0);
  endtask

  task automatic test_backpressure;
    logic [7:0] exp_v [5];
    exp_v[0] = 8'h02; exp_v[1] = 8'h04; exp_v[2] = 8'h08; exp_v[3] = 8'h10; exp_v[4] = 8'h20;
    b0.en = 1'b0;
    for (int i = 1; i <= 4; i++) push_code(1'b0, 3'(i));
    n_cmp++; if (b0.code_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b want 0", b0.code_ready); end
    n_cmp++; if (b0.level !== 3'd4) begin n_err++; $display("FAIL bp_full_level: got %0d want 4", b0.level); end
    b0.code_in = 3'd5; b0.code_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (b0.level !== 3'd4) begin n_err++; $display("FAIL bp_held_level: got %0d want 4", b0.level); end
    n_cmp++; if (b0.out !== 8'h00) begin n_err++; $display("FAIL bp_held_out: got %h want 00", b0.out); end
    b0.en = 1'b1;
    @(negedge clk);
    n_cmp++; if (b0.code_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %b want 1", b0.code_ready); end
    n_cmp++; if (b0.level !== 3'd3) begin n_err++; $display("FAIL bp_pop_level: got %0d want 3", b0.level); end
    n_cmp++; if (b0.out !== 8'h02) begin n_err++; $display("FAIL bp_first_out: got %h want 02", b0.out); end
    @(negedge clk);
    n_cmp++; if (b0.level !== 3'd4) begin n_err++; $display("FAIL bp_fifth_level: got %0d want 4", b0.level); end
    b0.code_valid = 1'b0;
    capture(1'b0, 30);
    n_cmp++; if (cap_n !== 5) begin n_err++; $display("FAIL bp_count: got %0d pulses want 5", cap_n); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (cap_val[i] !== exp_v[i]) begin
        n_err++; $display("FAIL bp_val[%0d]: got %h want %h", i, cap_val[i], exp_v[i]);
      end
    end
    wait_idle(1'b0);
  endtask

  task automatic test_single;
    b0.en = 1'b1;
    push_code(1'b0, 3'd5);
    n_cmp++; if (b0.out !== 8'h00) begin n_err++; $display("FAIL single_e0_out: got %h want 00", b0.out); end
    n_cmp++; if (b0.level !== 3'd1) begin n_err++; $display("FAIL single_e0_level: got %0d want 1", b0.level); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (b0.out !== 8'h20) begin n_err++; $display("FAIL single_hold[%0d]: got %h want 20", i, b0.out); end
      n_cmp++;
      if (b0.done !== 1'b0) begin n_err++; $display("FAIL single_nodone[%0d]: got %b want 0", i, b0.done); end
    end
    n_cmp++; if (b0.busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", b0.busy); end
    @(negedge clk);
    n_cmp++; if (b0.out !== 8'h00) begin n_err++; $display("FAIL single_end_out: got %h want 00", b0.out); end
    n_cmp++; if (b0.done !== 1'b1) begin n_err++; $display("FAIL single_done: got %b want 1", b0.done); end
    n_cmp++; if (b0.busy !== 1'b1) begin n_err++; $display("FAIL single_gap_busy: got %b want 1", b0.busy); end
    @(negedge clk);
    n_cmp++; if (b0.busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy: got %b want 0", b0.busy); end
    n_cmp++; if (b0.done !== 1'b0) begin n_err++; $display("FAIL single_done_drop: got %b want 0", b0.done); end
  endtask

  task automatic test_abort;
    b0.en = 1'b1;
    push_code(1'b0, 3'd2);
    push_code(1'b0, 3'd6);
    n_cmp++; if (b0.out !== 8'h04) begin n_err++; $display("FAIL abort_hold1: got %h want 04", b0.out); end
    push_code(1'b0, 3'd7);
    n_cmp++; if (b0.out !== 8'h04) begin n_err++; $display("FAIL abort_hold2: got %h want 04", b0.out); end
    b0.en = 1'b0;
    @(negedge clk);
    n_cmp++; if (b0.out !== 8'h00) begin n_err++; $display("FAIL abort_out: got %h want 00", b0.out); end
    n_cmp++; if (b0.done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b want 0", b0.done); end
    n_cmp++; if (b0.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", b0.busy); end
    n_cmp++; if (b0.level !== 3'd2) begin n_err++; $display("FAIL abort_level: got %0d want 2", b0.level); end
    repeat (2) @(negedge clk);
    n_cmp++; if (b0.out !== 8'h00) begin n_err++; $display("FAIL abort_stall_out: got %h want 00", b0.out); end
    b0.en = 1'b1;
    capture(1'b0, 20);
    n_cmp++; if (cap_n !== 2) begin n_err++; $display("FAIL abort_replay_count: got %0d want 2", cap_n); end
    n_cmp++; if (cap_val[0] !== 8'h40) begin n_err++; $display("FAIL abort_replay0: got %h want 40", cap_val[0]); end
    n_cmp++; if (cap_val[1] !== 8'h80) begin n_err++; $display("FAIL abort_replay1: got %h want 80", cap_val[1]); end
    n_cmp++; if (cap_done !== 2) begin n_err++; $display("FAIL abort_replay_done: got %0d want 2", cap_done); end
    wait_idle(1'b0);
  endtask

  task automatic test_push_pop;
    b0.en = 1'b0;
    push_code(1'b0, 3'd3);
    push_code(1'b0, 3'd4);
    n_cmp++; if (b0.level !== 3'd2) begin n_err++; $display("FAIL pp_pre_level: got %0d want 2", b0.level); end
    b0.en = 1'b1; b0.code_in = 3'd6; b0.code_valid = 1'b1;
    @(negedge clk);
    b0.code_valid = 1'b0;
    n_cmp++; if (b0.level !== 3'd2) begin n_err++; $display("FAIL pp_level: got %0d want 2", b0.level); end
    n_cmp++; if (b0.out !== 8'h08) begin n_err++; $display("FAIL pp_out: got %h want 08", b0.out); end
    wait_idle(1'b0);
  endtask

  task automatic test_back_to_back;
    b1.en = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) push_code(1'b1, 3'(i));
      end
      capture(1'b1, 16);
    join
    n_cmp++; if (cap_n !== 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", cap_n); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (cap_val[i] !== (8'h01 << i)) begin
        n_err++; $display("FAIL b2b_val[%0d]: got %h want %h", i, cap_val[i], 8'h01 << i);
      end
      n_cmp++;
      if (cap_len[i] !== 1) begin n_err++; $display("FAIL b2b_len[%0d]: got %0d want 1", i, cap_len[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (cap_gap[i] !== 1) begin n_err++; $display("FAIL b2b_gap[%0d]: got %0d want 1", i, cap_gap[i]); end
    end
    n_cmp++; if (cap_done !== 4) begin n_err++; $display("FAIL b2b_done: got %0d want 4", cap_done); end
    wait_idle(1'b1);
  endtask

  task automatic test_async_reset;
    b0.en = 1'b1;
    for (int i = 1; i <= 4; i++) push_code(1'b0, 3'(i));
    n_cmp++; if (b0.level !== 3'd3) begin n_err++; $display("FAIL arst_pre_level: got %0d want 3", b0.level); end
    n_cmp++; if (b0.out !== 8'h02) begin n_err++; $display("FAIL arst_pre_out: got %h want 02", b0.out); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (b0.out !== 8'h00) begin n_err++; $display("FAIL arst_out: got %h want 00", b0.out); end
    n_cmp++; if (b0.level !== 3'd0) begin n_err++; $display("FAIL arst_level: got %0d want 0", b0.level); end
    n_cmp++; if (b0.busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b want 0", b0.busy); end
    n_cmp++; if (b0.code_ready !== 1'b1) begin n_err++; $display("FAIL arst_ready: got %b want 1", b0.code_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (b0.out !== 8'h00) begin n_err++; $display("FAIL arst_after_out: got %h want 00", b0.out); end
    n_cmp++; if (b0.level !== 3'd0) begin n_err++; $display("FAIL arst_after_level: got %0d want 0", b0.level); end
  endtask

  initial begin
    rst_n         = 1'b0;
    b0.en         = 1'b1;
    b0.code_in    = '0;
    b0.code_valid = 1'b0;
    b1.en         = 1'b1;
    b1.code_in    = '0;
    b1.code_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequence();
    test_backpressure();
    test_single();
    test_abort();
    test_push_pop();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
